// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the 1101 detector: valid/ready word load, one bit per shift_strobe.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_valid,
    input  logic [NUM_BITS-1:0] load_data,
    output logic                load_ready,
    input  logic                shift_strobe,
    output logic                serial_out,
    output logic                serial_valid,
    output logic                frame_done
);

    localparam int CW = $clog2(NUM_BITS + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef SERIALIZER_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] w_shift_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic                r_load_ready;
    logic                w_load_ready_next;
    logic                r_serial_out;
    logic                w_serial_out_next;
    logic                r_serial_valid;
    logic                w_serial_valid_next;
    logic                r_frame_done;
    logic                w_frame_done_next;
    logic [NUM_BITS-1:0] w_shifted;
    logic                w_head_bit;
`ifdef SERIALIZER_PARITY_EN
    logic                r_parity;
    logic                w_parity_next;
`endif

    // The bit on the wire is always the head of the shift register.
    assign w_shifted  = SHIFT_MSB ? {r_shift[NUM_BITS-2:0], 1'b0} : {1'b0, r_shift[NUM_BITS-1:1]};
    assign w_head_bit = SHIFT_MSB ? w_shift_next[NUM_BITS-1] : w_shift_next[0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_load_ready   <= 1'b1;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_frame_done   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_next;
            r_shift        <= w_shift_next;
            r_cnt          <= w_cnt_next;
            r_load_ready   <= w_load_ready_next;
            r_serial_out   <= w_serial_out_next;
            r_serial_valid <= w_serial_valid_next;
            r_frame_done   <= w_frame_done_next;
`ifdef SERIALIZER_PARITY_EN
            r_parity       <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_cnt_next        = r_cnt;
        w_frame_done_next = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        w_parity_next     = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_shift_next = load_data;
                    w_cnt_next   = '0;
                    w_state_next = ST_SHIFT;
`ifdef SERIALIZER_PARITY_EN
                    w_parity_next = ^load_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (shift_strobe) begin
                    w_shift_next = w_shifted;
                    w_cnt_next   = r_cnt + CW'(1);
                    if (r_cnt == LAST_IDX) begin
`ifdef SERIALIZER_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next      = ST_IDLE;
                        w_frame_done_next = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (shift_strobe) begin
                    w_cnt_next        = r_cnt + CW'(1);
                    w_state_next      = ST_IDLE;
                    w_frame_done_next = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they land in registers.
        w_load_ready_next   = (w_state_next == ST_IDLE);
        w_serial_valid_next = (w_state_next != ST_IDLE);
        w_serial_out_next   = 1'b0;
        if (w_state_next == ST_SHIFT) begin
            w_serial_out_next = w_head_bit;
        end
`ifdef SERIALIZER_PARITY_EN
        if (w_state_next == ST_PARITY) begin
            w_serial_out_next = w_parity_next;
        end
`endif
    end

    assign load_ready   = r_load_ready;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance share one stimulus.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_strobe = 1'b0;

    logic a_ready, a_out, a_valid, a_done;
    logic b_ready, b_out, b_valid, b_done;
    logic sel = 1'b0;
    logic o_ready, o_out, o_valid, o_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bit_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_msb (
        .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(a_ready), .shift_strobe(shift_strobe), .serial_out(a_out),
        .serial_valid(a_valid), .frame_done(a_done)
    );

    bit_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(b_ready), .shift_strobe(shift_strobe), .serial_out(b_out),
        .serial_valid(b_valid), .frame_done(b_done)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_out   = sel ? b_out   : a_out;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_done  = sel ? b_done  : a_done;

    typedef struct {
        logic [7:0] data;
        logic       lsb;
        int         per;
        logic [7:0] seq;   // expected bits in transmit order, [7] first
        logic       par;
        string      name;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, o_ready, 1'b1);
        chk({nm, "_out"},   o_out,   1'b0);
        chk({nm, "_valid"}, o_valid, 1'b0);
        chk({nm, "_done"},  o_done,  1'b0);
    endtask

    // Called at a negedge. With skip_load the handshake already happened on the previous edge.
    task automatic do_frame(input string nm, input logic [7:0] d, input int per,
                            input logic [7:0] seq, input logic par,
                            input logic pend, input logic [7:0] pdata, input logic skip_load);
        logic e;
        if (!skip_load) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = d;
            chk({nm, "_ready_idle"}, o_ready, 1'b1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            e = (i < 8) ? seq[7-i] : par;
            for (int k = 0; k < per; k++) begin
                if (pend && i == 3 && k == 0) begin
                    load_valid = 1'b1;
                    load_data  = pdata;
                end
                chk($sformatf("%s_bit%0d", nm, i), o_out, e);
                chk($sformatf("%s_valid%0d", nm, i), o_valid, 1'b1);
                chk($sformatf("%s_busy%0d", nm, i), o_ready, 1'b0);
                chk($sformatf("%s_nodone%0d", nm, i), o_done, 1'b0);
                shift_strobe = (k == per - 1);
                @(negedge clk);
            end
        end
        shift_strobe = 1'b0;
        chk({nm, "_done"},      o_done,  1'b1);
        chk({nm, "_done_valid"}, o_valid, 1'b0);
        chk({nm, "_done_out"},   o_out,   1'b0);
        chk({nm, "_done_ready"}, o_ready, 1'b1);
        @(negedge clk);
        chk({nm, "_done_pulse"}, o_done, 1'b0);
        if (pend) chk({nm, "_pend_taken"}, o_ready, 1'b0);
        $display("frame %s data=%h checked", nm, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{data: 8'hD2, lsb: 1'b0, per: 1, seq: 8'b1101_0010, par: 1'b0, name: "msb_d2"};
        vt[1] = '{data: 8'h0B, lsb: 1'b1, per: 3, seq: 8'b1101_0000, par: 1'b1, name: "lsb_0b_p3"};
        vt[2] = '{data: 8'hD2, lsb: 1'b1, per: 1, seq: 8'b0100_1011, par: 1'b0, name: "lsb_d2"};
        vt[3] = '{data: 8'hB4, lsb: 1'b0, per: 1, seq: 8'b1011_0100, par: 1'b0, name: "msb_b4"};
        vt[4] = '{data: 8'hB5, lsb: 1'b0, per: 2, seq: 8'b1011_0101, par: 1'b1, name: "msb_b5_p2"};

        // Reset with random inputs, then release with no load.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            load_valid   = 1'($urandom_range(0, 1));
            load_data    = 8'($urandom);
            shift_strobe = 1'($urandom_range(0, 1));
            #1;
            sel = 1'b0; chk_idle("rst_msb");
            sel = 1'b1; chk_idle("rst_lsb");
        end
        @(negedge clk);
        load_valid = 1'b0;
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            shift_strobe = 1'($urandom_range(0, 1));
            @(negedge clk);
            sel = 1'b0; chk_idle("post_rst");
        end
        shift_strobe = 1'b0;

        for (int v = 0; v < 5; v++) begin
            sel = vt[v].lsb;
            do_frame(vt[v].name, vt[v].data, vt[v].per, vt[v].seq, vt[v].par, 1'b0, 8'h00, 1'b0);
        end

        // Load while busy is ignored, then accepted in the frame_done cycle.
        sel = 1'b0;
        do_frame("ff_pend", 8'hFF, 1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
        do_frame("after_pend", 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-frame after three bits of A5.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hA5;
        @(negedge clk);
        load_valid   = 1'b0;
        shift_strobe = 1'b1;
        chk("a5_bit0", o_out, 1'b1);
        @(negedge clk);
        chk("a5_bit1", o_out, 1'b0);
        @(negedge clk);
        chk("a5_bit2", o_out, 1'b1);
        @(negedge clk);
        chk("a5_bit3", o_out, 1'b0);
        chk("a5_valid3", o_valid, 1'b1);
        n_rst = 1'b0;
        #1;
        chk_idle("midrst");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            load_valid   = 1'($urandom_range(0, 1));
            shift_strobe = 1'($urandom_range(0, 1));
            #1;
            chk_idle("midrst_hold");
        end
        @(negedge clk);
        load_valid   = 1'b0;
        shift_strobe = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("midrst_rel");
        do_frame("msb_3c", 8'h3C, 1, 8'b0011_1100, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
